// File: rtl/friet_stream_sequencer_in.sv
// friet_stream_sequencer_in
// Merges the key, nonce, associated-data and message producer streams into the
// single input port of friet_stream_buffer_in, in the fixed order
// KEY -> NONCE -> AD -> MSG. The last word of every phase carries last=1, so
// the buffer flushes at each phase boundary. The data path is a zero-latency
// combinational mux selected by the registered phase state. Only the phase
// state, the word counter, the latched configuration bits and the message byte
// counter are stored.
module friet_stream_sequencer_in #(
   parameter int DIN_WIDTH      = 32,
   parameter int DIN_SIZE_WIDTH = 2,
   parameter int KEY_WORDS      = 4,
   parameter int NONCE_WORDS    = 4,
   parameter int COUNT_WIDTH    = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   // operation request
   input  logic                      start,
   output logic                      start_ready,
   input  logic                      cfg_ad_present,
   input  logic                      cfg_msg_present,
   // key stream (full words only)
   input  logic [DIN_WIDTH-1:0]      key_din,
   input  logic                      key_valid,
   output logic                      key_ready,
   // nonce stream (full words only)
   input  logic [DIN_WIDTH-1:0]      nonce_din,
   input  logic                      nonce_valid,
   output logic                      nonce_ready,
   // associated-data stream
   input  logic [DIN_WIDTH-1:0]      ad_din,
   input  logic [DIN_SIZE_WIDTH:0]   ad_size,
   input  logic                      ad_last,
   input  logic                      ad_valid,
   output logic                      ad_ready,
   // message stream
   input  logic [DIN_WIDTH-1:0]      msg_din,
   input  logic [DIN_SIZE_WIDTH:0]   msg_size,
   input  logic                      msg_last,
   input  logic                      msg_valid,
   output logic                      msg_ready,
   // buffer input port
   output logic [DIN_WIDTH-1:0]      buf_din,
   output logic [DIN_SIZE_WIDTH:0]   buf_din_size,
   output logic                      buf_din_last,
   output logic                      buf_din_valid,
   input  logic                      buf_din_ready,
   // status towards the permutation control
   output logic [2:0]                phase,
   output logic                      busy,
   output logic                      done,
   output logic [COUNT_WIDTH-1:0]    msg_byte_count
);

   localparam int MAX_WORDS = (KEY_WORDS > NONCE_WORDS) ? KEY_WORDS : NONCE_WORDS;
   localparam int CNT_W     = $clog2(MAX_WORDS) + 1;
   localparam int SZ_W      = DIN_SIZE_WIDTH + 1;

   // Key and nonce words are always full words.
   localparam logic [SZ_W-1:0]  FULL_SIZE      = SZ_W'(2 ** DIN_SIZE_WIDTH);
   localparam logic [CNT_W-1:0] KEY_LAST_IDX   = CNT_W'(KEY_WORDS - 1);
   localparam logic [CNT_W-1:0] NONCE_LAST_IDX = CNT_W'(NONCE_WORDS - 1);

   // The encoding doubles as the externally visible phase number.
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_KEY   = 3'd1,
      S_NONCE = 3'd2,
      S_AD    = 3'd3,
      S_MSG   = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t                  r_state;
   logic [CNT_W-1:0]        r_word_cnt;
   logic                    r_cfg_ad;
   logic                    r_cfg_msg;
   logic [COUNT_WIDTH-1:0]  r_msg_byte_count;

   logic                    w_sel_valid;
   logic                    w_key_last;
   logic                    w_nonce_last;
   logic                    w_hs;
   state_t                  w_after_nonce;
   state_t                  w_after_ad;

   assign w_key_last   = (r_word_cnt == KEY_LAST_IDX);
   assign w_nonce_last = (r_word_cnt == NONCE_LAST_IDX);
   assign w_hs         = w_sel_valid & buf_din_ready;

   // Choose the phase that follows NONCE and AD from the configuration latched at start.
   always_comb begin
      w_after_nonce = S_DONE;
      w_after_ad    = S_DONE;
      if (r_cfg_ad) begin
         w_after_nonce = S_AD;
      end else if (r_cfg_msg) begin
         w_after_nonce = S_MSG;
      end else begin
         w_after_nonce = S_DONE;
      end
      if (r_cfg_msg) begin
         w_after_ad = S_MSG;
      end else begin
         w_after_ad = S_DONE;
      end
   end

   // Route the active phase's producer to the buffer and return the buffer's ready to it alone.
   always_comb begin
      w_sel_valid  = 1'b0;
      buf_din      = {DIN_WIDTH{1'b0}};
      buf_din_size = {SZ_W{1'b0}};
      buf_din_last = 1'b0;
      key_ready    = 1'b0;
      nonce_ready  = 1'b0;
      ad_ready     = 1'b0;
      msg_ready    = 1'b0;
      case (r_state)
         S_KEY: begin
            w_sel_valid  = key_valid;
            buf_din      = key_din;
            buf_din_size = FULL_SIZE;
            buf_din_last = w_key_last;
            key_ready    = buf_din_ready;
         end
         S_NONCE: begin
            w_sel_valid  = nonce_valid;
            buf_din      = nonce_din;
            buf_din_size = FULL_SIZE;
            buf_din_last = w_nonce_last;
            nonce_ready  = buf_din_ready;
         end
         S_AD: begin
            w_sel_valid  = ad_valid;
            buf_din      = ad_din;
            buf_din_size = ad_size;
            buf_din_last = ad_last;
            ad_ready     = buf_din_ready;
         end
         S_MSG: begin
            w_sel_valid  = msg_valid;
            buf_din      = msg_din;
            buf_din_size = msg_size;
            buf_din_last = msg_last;
            msg_ready    = buf_din_ready;
         end
         default: begin
            // IDLE, DONE and unused encodings present an idle, all-zero port.
            w_sel_valid  = 1'b0;
         end
      endcase
   end

   assign buf_din_valid  = w_sel_valid;
   assign phase          = r_state;
   assign busy           = (r_state != S_IDLE);
   assign done           = (r_state == S_DONE);
   assign start_ready    = (r_state == S_IDLE);
   assign msg_byte_count = r_msg_byte_count;

   // Phase sequencing, per-phase word counting and message byte accumulation.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state          <= S_IDLE;
         r_word_cnt       <= {CNT_W{1'b0}};
         r_cfg_ad         <= 1'b0;
         r_cfg_msg        <= 1'b0;
         r_msg_byte_count <= {COUNT_WIDTH{1'b0}};
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_cfg_ad         <= cfg_ad_present;
                  r_cfg_msg        <= cfg_msg_present;
                  r_word_cnt       <= {CNT_W{1'b0}};
                  r_msg_byte_count <= {COUNT_WIDTH{1'b0}};
                  r_state          <= S_KEY;
               end else begin
                  r_state          <= S_IDLE;
               end
            end
            S_KEY: begin
               if (w_hs && w_key_last) begin
                  r_word_cnt <= {CNT_W{1'b0}};
                  r_state    <= S_NONCE;
               end else if (w_hs) begin
                  r_word_cnt <= r_word_cnt + CNT_W'(1);
               end else begin
                  r_word_cnt <= r_word_cnt;
               end
            end
            S_NONCE: begin
               if (w_hs && w_nonce_last) begin
                  r_word_cnt <= {CNT_W{1'b0}};
                  r_state    <= w_after_nonce;
               end else if (w_hs) begin
                  r_word_cnt <= r_word_cnt + CNT_W'(1);
               end else begin
                  r_word_cnt <= r_word_cnt;
               end
            end
            S_AD: begin
               if (w_hs && ad_last) begin
                  r_state <= w_after_ad;
               end else begin
                  r_state <= S_AD;
               end
            end
            S_MSG: begin
               if (w_hs) begin
                  // Zero-extended add; wraps modulo 2**COUNT_WIDTH.
                  r_msg_byte_count <= r_msg_byte_count + COUNT_WIDTH'(msg_size);
               end else begin
                  r_msg_byte_count <= r_msg_byte_count;
               end
               if (w_hs && msg_last) begin
                  r_state <= S_DONE;
               end else begin
                  r_state <= S_MSG;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_friet_stream_sequencer_in.sv
// Directed bench for friet_stream_sequencer_in. Expected words are listed in a
// small table (channel, data, size, last) and replayed against the DUT.
// Inputs change on the falling edge, and outputs are checked 1 ns later.
module tb_friet_stream_sequencer_in;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        start_ready;
   logic        cfg_ad_present = 1'b0;
   logic        cfg_msg_present = 1'b0;
   logic [31:0] key_din = 32'd0;
   logic        key_valid = 1'b0;
   logic        key_ready;
   logic [31:0] nonce_din = 32'd0;
   logic        nonce_valid = 1'b0;
   logic        nonce_ready;
   logic [31:0] ad_din = 32'd0;
   logic [2:0]  ad_size = 3'd0;
   logic        ad_last = 1'b0;
   logic        ad_valid = 1'b0;
   logic        ad_ready;
   logic [31:0] msg_din = 32'd0;
   logic [2:0]  msg_size = 3'd0;
   logic        msg_last = 1'b0;
   logic        msg_valid = 1'b0;
   logic        msg_ready;
   logic [31:0] buf_din;
   logic [2:0]  buf_din_size;
   logic        buf_din_last;
   logic        buf_din_valid;
   logic        buf_din_ready = 1'b0;
   logic [2:0]  phase;
   logic        busy;
   logic        done;
   logic [15:0] msg_byte_count;

   int n_cmp = 0;
   int n_err = 0;

   // expected word table
   int          t_n;
   int          t_ch  [0:31];
   logic [31:0] t_dat [0:31];
   logic [2:0]  t_sz  [0:31];
   logic        t_lst [0:31];

   friet_stream_sequencer_in dut (
      .clk(clk), .rst(rst),
      .start(start), .start_ready(start_ready),
      .cfg_ad_present(cfg_ad_present), .cfg_msg_present(cfg_msg_present),
      .key_din(key_din), .key_valid(key_valid), .key_ready(key_ready),
      .nonce_din(nonce_din), .nonce_valid(nonce_valid), .nonce_ready(nonce_ready),
      .ad_din(ad_din), .ad_size(ad_size), .ad_last(ad_last), .ad_valid(ad_valid), .ad_ready(ad_ready),
      .msg_din(msg_din), .msg_size(msg_size), .msg_last(msg_last), .msg_valid(msg_valid), .msg_ready(msg_ready),
      .buf_din(buf_din), .buf_din_size(buf_din_size), .buf_din_last(buf_din_last),
      .buf_din_valid(buf_din_valid), .buf_din_ready(buf_din_ready),
      .phase(phase), .busy(busy), .done(done), .msg_byte_count(msg_byte_count)
   );

   // free-running clock, 10 ns period
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] rdy_vec();
      return {key_ready, nonce_ready, ad_ready, msg_ready};
   endfunction

   task automatic add(input int ch, input logic [31:0] d, input logic [2:0] sz, input logic lst);
      t_ch[t_n]  = ch;
      t_dat[t_n] = d;
      t_sz[t_n]  = sz;
      t_lst[t_n] = lst;
      t_n++;
   endtask

   // four key and four nonce words; last flag expected on the fourth word of each
   task automatic add_key_nonce(input logic [31:0] base);
      for (int i = 0; i < 4; i++) add(0, base + 32'(i), 3'd4, (i == 3));
      for (int i = 0; i < 4; i++) add(1, base + 32'h100 + 32'(i), 3'd4, (i == 3));
   endtask

   task automatic clear_inputs();
      key_valid = 1'b0; nonce_valid = 1'b0; ad_valid = 1'b0; msg_valid = 1'b0;
      key_din = 32'hDEAD_0000; nonce_din = 32'hDEAD_1111;
      ad_din = 32'hDEAD_2222; msg_din = 32'hDEAD_3333;
      ad_size = 3'd0; ad_last = 1'b0; msg_size = 3'd0; msg_last = 1'b0;
   endtask

   // called at a falling edge: request a start and confirm KEY is entered
   task automatic do_start(input logic ad_p, input logic msg_p, input bit hold);
      cfg_ad_present = ad_p;
      cfg_msg_present = msg_p;
      start = 1'b1;
      #1;
      chk("start_ready_idle", 32'(start_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      if (!hold) start = 1'b0;
      cfg_ad_present = 1'b0;
      cfg_msg_present = 1'b0;
      #1;
      chk("phase_after_start", 32'(phase), 32'd1);
      chk("start_ready_busy", 32'(start_ready), 32'd0);
   endtask

   // replay table entries [from, to); returns at a falling edge
   task automatic run_seq(input int from, input int to, input bit rnd);
      int i;
      int cyc;
      logic v;
      logic r;
      i = from;
      cyc = 0;
      while (i < to && cyc < 40 * (to - from) + 50) begin
         v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         clear_inputs();
         buf_din_ready = r;
         case (t_ch[i])
            0: begin key_din = t_dat[i]; key_valid = v; end
            1: begin nonce_din = t_dat[i]; nonce_valid = v; end
            2: begin ad_din = t_dat[i]; ad_size = t_sz[i]; ad_last = t_lst[i]; ad_valid = v; end
            default: begin msg_din = t_dat[i]; msg_size = t_sz[i]; msg_last = t_lst[i]; msg_valid = v; end
         endcase
         #1;
         if (v) begin
            chk($sformatf("phase_w%0d", i), 32'(phase), 32'(t_ch[i] + 1));
            chk($sformatf("valid_w%0d", i), 32'(buf_din_valid), 32'd1);
            chk($sformatf("din_w%0d", i), buf_din, t_dat[i]);
            chk($sformatf("size_w%0d", i), 32'(buf_din_size), 32'(t_sz[i]));
            chk($sformatf("last_w%0d", i), 32'(buf_din_last), 32'(t_lst[i]));
            chk($sformatf("ready_w%0d", i), 32'(rdy_vec()), r ? 32'(4'b1000 >> t_ch[i]) : 32'd0);
         end
         @(posedge clk);
         if (v && r) i++;
         @(negedge clk);
         cyc++;
      end
      if (i < to) chk("seq_timeout", 32'(i), 32'(to));
      clear_inputs();
   endtask

   // called at the falling edge after the final handshake: DONE then IDLE
   task automatic finish_check(input logic [15:0] exp_cnt, input bit exp_idle_start);
      key_valid = 1'b1; nonce_valid = 1'b1; ad_valid = 1'b1; msg_valid = 1'b1;
      ad_last = 1'b1; msg_last = 1'b1; ad_size = 3'd4; msg_size = 3'd4;
      buf_din_ready = 1'b1;
      #1;
      chk("phase_done", 32'(phase), 32'd5);
      chk("done_pulse", 32'(done), 32'd1);
      chk("busy_done", 32'(busy), 32'd1);
      chk("start_ready_done", 32'(start_ready), 32'd0);
      chk("ready_done", 32'(rdy_vec()), 32'd0);
      chk("valid_done", 32'(buf_din_valid), 32'd0);
      chk("bus_done", {buf_din[28:0], buf_din_size}, 32'd0);
      chk("last_done", 32'(buf_din_last), 32'd0);
      chk("count_done", 32'(msg_byte_count), 32'(exp_cnt));
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("phase_idle", 32'(phase), 32'd0);
      chk("done_cleared", 32'(done), 32'd0);
      chk("start_ready_idle2", 32'(start_ready), exp_idle_start ? 32'd1 : 32'd0);
      chk("ready_idle", 32'(rdy_vec()), 32'd0);
      chk("valid_idle", 32'(buf_din_valid), 32'd0);
      chk("count_hold", 32'(msg_byte_count), 32'(exp_cnt));
      clear_inputs();
      buf_din_ready = 1'b0;
   endtask

   initial begin
      clear_inputs();
      // reset state
      #3;
      chk("rst_phase", 32'(phase), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_start_ready", 32'(start_ready), 32'd1);
      chk("rst_count", 32'(msg_byte_count), 32'd0);
      buf_din_ready = 1'b1;
      key_valid = 1'b1;
      #1;
      chk("rst_ready", 32'(rdy_vec()), 32'd0);
      chk("rst_valid", 32'(buf_din_valid), 32'd0);
      clear_inputs();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // 1: full operation, no backpressure; AD sizes 4,4,2; MSG sizes 4,3 -> count 7
      t_n = 0;
      add_key_nonce(32'hA000_0000);
      add(2, 32'hAD00_0000, 3'd4, 1'b0);
      add(2, 32'hAD00_0001, 3'd4, 1'b0);
      add(2, 32'hAD00_0002, 3'd2, 1'b1);
      add(3, 32'h3500_0000, 3'd4, 1'b0);
      add(3, 32'h3500_0001, 3'd3, 1'b1);
      do_start(1'b1, 1'b1, 1'b0);
      run_seq(0, t_n, 1'b0);
      finish_check(16'd7, 1'b1);

      // 2: no AD, no MSG -> NONCE straight to DONE; AD/MSG readys never raised
      t_n = 0;
      add_key_nonce(32'hB000_0000);
      do_start(1'b0, 1'b0, 1'b0);
      run_seq(0, t_n, 1'b0);
      finish_check(16'd0, 1'b1);

      // 3: random ready and valid stalls; MSG sizes 4,4,2 -> count 10
      t_n = 0;
      add_key_nonce(32'hC000_0000);
      add(2, 32'hCAD0_0000, 3'd4, 1'b0);
      add(2, 32'hCAD0_0001, 3'd1, 1'b1);
      add(3, 32'hC350_0000, 3'd4, 1'b0);
      add(3, 32'hC350_0001, 3'd4, 1'b0);
      add(3, 32'hC350_0002, 3'd2, 1'b1);
      do_start(1'b1, 1'b1, 1'b0);
      run_seq(0, t_n, 1'b1);
      finish_check(16'd10, 1'b1);

      // 4: empty terminator after a size-4 word -> count 4
      t_n = 0;
      add_key_nonce(32'hD000_0000);
      add(3, 32'hD350_0000, 3'd4, 1'b0);
      add(3, 32'hD350_0001, 3'd0, 1'b1);
      do_start(1'b0, 1'b1, 1'b0);
      run_seq(0, t_n, 1'b0);
      finish_check(16'd4, 1'b1);

      // 5: asynchronous reset while AD word 1 is presented
      t_n = 0;
      add_key_nonce(32'hE000_0000);
      add(2, 32'hEAD0_0000, 3'd4, 1'b0);
      do_start(1'b1, 1'b1, 1'b0);
      run_seq(0, t_n, 1'b0);
      ad_din = 32'hEAD0_0001; ad_size = 3'd4; ad_valid = 1'b1; buf_din_ready = 1'b1;
      #1;
      chk("pre_rst_ad_ready", 32'(ad_ready), 32'd1);
      #1;
      rst = 1'b0;
      #1;
      chk("async_phase", 32'(phase), 32'd0);
      chk("async_busy", 32'(busy), 32'd0);
      chk("async_ready", 32'(rdy_vec()), 32'd0);
      chk("async_valid", 32'(buf_din_valid), 32'd0);
      chk("async_start_ready", 32'(start_ready), 32'd1);
      clear_inputs();
      buf_din_ready = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      t_n = 0;
      add_key_nonce(32'hF000_0000);
      add(3, 32'hF350_0000, 3'd3, 1'b1);
      do_start(1'b0, 1'b1, 1'b0);
      run_seq(0, t_n, 1'b0);
      finish_check(16'd3, 1'b1);

      // 6: start held high throughout; no restart until IDLE, then re-accepted
      t_n = 0;
      add_key_nonce(32'h1000_0000);
      add(3, 32'h1350_0000, 3'd2, 1'b1);
      do_start(1'b0, 1'b1, 1'b1);
      run_seq(0, t_n, 1'b0);
      finish_check(16'd2, 1'b1);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("restart_phase", 32'(phase), 32'd1);
      chk("restart_count_clear", 32'(msg_byte_count), 32'd0);
      start = 1'b0;
      rst = 1'b0;
      #10;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/friet_stream_sequencer_in.md
# friet_stream_sequencer_in

Phase sequencer placed in front of `friet_stream_buffer_in`. It takes four producer streams (key, nonce, associated data, message) and merges them into the single input port of the buffer, in the fixed order KEY → NONCE → AD → MSG. It marks the last word of each phase so the buffer flushes at every phase boundary. It also reports the current phase and the message byte count to the permutation control.

## Interface
Parameters:
- `DIN_WIDTH`, 32, word width of every stream.
- `DIN_SIZE_WIDTH`, 2, log2 of bytes per word.
- `KEY_WORDS`, 4, fixed number of key words per operation.
- `NONCE_WORDS`, 4, fixed number of nonce words per operation.
- `COUNT_WIDTH`, 16, width of the message byte counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `start` in 1: operation request.
- `start_ready` out 1: high only in IDLE.
- `cfg_ad_present` in 1: sampled on start handshake; 0 skips the AD phase.
- `cfg_msg_present` in 1: sampled on start handshake; 0 skips the MSG phase.
- `key_din` in DIN_WIDTH, `key_valid` in 1, `key_ready` out 1: key stream, full words.
- `nonce_din` in DIN_WIDTH, `nonce_valid` in 1, `nonce_ready` out 1: nonce stream, full words.
- `ad_din` in DIN_WIDTH, `ad_size` in DIN_SIZE_WIDTH+1, `ad_last` in 1, `ad_valid` in 1, `ad_ready` out 1: AD stream.
- `msg_din` in DIN_WIDTH, `msg_size` in DIN_SIZE_WIDTH+1, `msg_last` in 1, `msg_valid` in 1, `msg_ready` out 1: message stream.
- `buf_din` out DIN_WIDTH, `buf_din_size` out DIN_SIZE_WIDTH+1, `buf_din_last` out 1, `buf_din_valid` out 1, `buf_din_ready` in 1: to the buffer input.
- `phase` out 3: 0 IDLE, 1 KEY, 2 NONCE, 3 AD, 4 MSG, 5 DONE.
- `busy` out 1: state is not IDLE.
- `done` out 1: one-cycle pulse in DONE.
- `msg_byte_count` out COUNT_WIDTH: sum of accepted MSG sizes.

## Operation
- **Registered state:** FSM state, word counter (width clog2(max(KEY_WORDS,NONCE_WORDS))+1), latched cfg bits, `msg_byte_count`.
- **IDLE:** `start_ready`=1. On `start`&`start_ready`:
  - latch the cfg bits;
  - clear `msg_byte_count` and the word counter;
  - go to KEY.
- **KEY:**
  - Forward `key_din`; `buf_din_size` = 2**DIN_SIZE_WIDTH.
  - `buf_din_last` = 1 when word counter = KEY_WORDS-1.
  - Counter increments per accepted word.
  - On the handshake of the last word, clear the counter and go to NONCE.
- **NONCE:** same as KEY with NONCE_WORDS. After the last word, go to:
  - AD if `cfg_ad_present`;
  - else MSG if `cfg_msg_present`;
  - else DONE.
- **AD:**
  - Forward `ad_din`, `ad_size` and `ad_last` unchanged.
  - On the handshake with `ad_last`=1, go to MSG if `cfg_msg_present`, else DONE.
- **MSG:**
  - Forward the `msg_*` signals unchanged.
  - `msg_byte_count` += `msg_size` (zero-extended, wraps modulo 2**COUNT_WIDTH) on each handshake.
  - On the handshake with `msg_last`=1, go to DONE.
- **DONE:** `done`=1 for one cycle, then go to IDLE. `msg_byte_count` holds until the next start.
- **Mux:** only the channel of the current phase sees `*_ready` = `buf_din_ready`; all other readys are 0. `buf_din_valid` = the selected valid. In IDLE and DONE, `buf_din_valid`=0 and `buf_din`/`buf_din_size`/`buf_din_last` are 0.
- **Size rules:**
  - AD/MSG non-last words have size 1..2**DIN_SIZE_WIDTH.
  - A last word may have size 0 (empty terminator); it is forwarded with last=1.
  - Sizes are not checked.

## Timing
- Data path is combinational, zero latency: `buf_din*` and `*_ready` follow the inputs in the same cycle.
- A phase change takes effect the cycle after the handshake of the last word; there are no bubbles beyond that.
- Start accepted at edge N → KEY forwarding is possible from cycle N+1.
- After the final handshake at edge M: DONE during cycle M+1, IDLE (`start_ready`=1) at cycle M+2.
- `start` is ignored while busy.
- **Reset values (`rst`=0, asynchronous):**
  - state IDLE; counter, cfg bits and `msg_byte_count` 0;
  - `phase`=0, `busy`=0, `done`=0;
  - all `*_ready`=0, `buf_din_valid`=0;
  - `start_ready`=1.
- **Reset mid-operation:** returns to IDLE immediately and drops all readys the same cycle. No partial-phase state survives.
- **Backpressure:** with `buf_din_ready`=0, no handshake occurs and state and counters hold.

## Test plan
- **Full operation, AD and MSG present, no backpressure:** 4 key, 4 nonce, 3 AD (last size 2), 2 MSG (sizes 4, 3).
  - `buf_din_last` high on key word 3, nonce word 3, AD word 2, MSG word 1.
  - `phase` steps 1,2,3,4,5,0.
  - `msg_byte_count`=7; `done` pulses once.
- **cfg_ad_present=0, cfg_msg_present=0:** NONCE goes directly to DONE; `ad_ready`/`msg_ready` stay 0 throughout.
- **Random `buf_din_ready` toggling (50%) and random producer valids:** words are forwarded exactly once and in order; counters are unaffected by stalls.
- **Empty terminator:** MSG word size 4, then size 0 with last. Both are forwarded; `msg_byte_count`=4; DONE follows.
- **rst asserted during AD word 1:** outputs go to their reset values asynchronously. After release a new start runs cleanly from KEY.
- **`start` held high while busy:** no restart occurs; accepted again only at the cycle `start_ready`=1 after DONE.
